// File: rtl/accumulator_control_unit.sv
// accumulator_control_unit
// Multi-cycle sequencer for the 8-bit accumulator core. It fetches instruction
// bytes over a request/valid handshake, decodes them, and drives the external
// 4-entry register file. It owns the accumulator, the ZERO/CARRY flags and the
// program counter. All control outputs come straight from flops: the
// values they take in the next state are decoded one cycle early.

module accumulator_control_unit #(
    parameter int unsigned       PC_W     = 8,
    parameter logic [PC_W-1:0]   RESET_PC = {PC_W{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             instr_req,
    output logic [PC_W-1:0]  instr_addr,
    input  logic             instr_valid,
    input  logic [7:0]       instr_data,
    output logic [1:0]       rf_addr,
    output logic             rf_we,
    output logic [7:0]       rf_wdata,
    input  logic [7:0]       rf_rdata,
    output logic [7:0]       acc,
    output logic             zero,
    output logic             carry,
    output logic             busy,
    output logic             halted,
    output logic             illegal
);

    // FSM encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_FETCH_OP = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;
    localparam logic [2:0] ST_HALT     = 3'd4;

    // Opcodes (instr[7:4])
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_JNZ = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    // Opcodes that carry a second (operand) byte.
    function automatic logic f_two_byte(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_JNZ);
    endfunction

    // Opcodes outside the defined set execute as NOP and raise illegal.
    function automatic logic f_illegal(input logic [3:0] op);
        logic res;
        case (op)
            OP_NOP, OP_LDA, OP_STA, OP_ADD, OP_SUB,
            OP_AND, OP_LDI, OP_JNZ, OP_HLT: res = 1'b0;
            default:                        res = 1'b1;
        endcase
        return res;
    endfunction

    // State and datapath registers
    logic [2:0]       r_state;
    logic [PC_W-1:0]  r_pc;
    logic [3:0]       r_op;
    logic [1:0]       r_reg;
    logic [7:0]       r_operand;
    logic [7:0]       r_acc;
    logic             r_zero;
    logic             r_carry;

    // Registered control outputs
    logic             r_instr_req;
    logic             r_busy;
    logic             r_halted;
    logic             r_rf_we;
    logic [1:0]       r_rf_addr;
    logic             r_illegal;

    // Combinational next values
    logic [2:0]       w_state_nxt;
    logic             w_hs;
    logic             w_start_ok;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [PC_W-1:0]  w_jump_pc;
    logic [3:0]       w_exec_op;
    logic [1:0]       w_exec_reg;
    logic             w_enter_exec;
    logic [8:0]       w_sum;
    logic [8:0]       w_diff;
    logic [7:0]       w_acc_nxt;
    logic             w_carry_nxt;
    logic             w_zero_upd;
    logic             w_zero_nxt;

    // A fetch byte is accepted only while the request is actually out.
    assign w_hs       = r_instr_req & instr_valid;
    // start is honoured only when the core is not running.
    assign w_start_ok = start & ((r_state == ST_IDLE) | (r_state == ST_HALT));
    assign w_jump_pc  = PC_W'(r_operand);

    // Next-state decode of the sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_nxt = ST_FETCH;
                else            w_state_nxt = ST_IDLE;
            end
            ST_FETCH: begin
                if (w_hs) begin
                    if (f_two_byte(instr_data[7:4])) w_state_nxt = ST_FETCH_OP;
                    else                              w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH_OP: begin
                if (w_hs) w_state_nxt = ST_EXEC;
                else      w_state_nxt = ST_FETCH_OP;
            end
            ST_EXEC: begin
                if (r_op == OP_HLT) w_state_nxt = ST_HALT;
                else                w_state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                if (w_start_ok) w_state_nxt = ST_FETCH;
                else            w_state_nxt = ST_HALT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Program counter: restart, post-increment per fetched byte, or JNZ target.
    always_comb begin
        w_pc_nxt = r_pc;
        if (w_start_ok) begin
            w_pc_nxt = RESET_PC;
        end else if (w_hs) begin
            w_pc_nxt = r_pc + PC_ONE;
        end else if ((r_state == ST_EXEC) && (r_op == OP_JNZ) && !r_zero) begin
            w_pc_nxt = w_jump_pc;
        end else begin
            w_pc_nxt = r_pc;
        end
    end

    // Opcode/register that will be executed if the next state is EXEC.
    always_comb begin
        w_exec_op  = r_op;
        w_exec_reg = r_reg;
        if (r_state == ST_FETCH) begin
            w_exec_op  = instr_data[7:4];
            w_exec_reg = instr_data[1:0];
        end else begin
            w_exec_op  = r_op;
            w_exec_reg = r_reg;
        end
        w_enter_exec = (w_state_nxt == ST_EXEC);
    end

    // ALU and flag update for the instruction in EXEC; the register file
    // read data is valid for the EXEC cycle because rf_addr already holds r.
    always_comb begin
        w_sum       = {1'b0, r_acc} + {1'b0, rf_rdata};
        w_diff      = {1'b0, r_acc} - {1'b0, rf_rdata};
        w_acc_nxt   = r_acc;
        w_carry_nxt = r_carry;
        w_zero_upd  = 1'b0;
        if (r_state == ST_EXEC) begin
            case (r_op)
                OP_LDA: begin
                    w_acc_nxt  = rf_rdata;
                    w_zero_upd = 1'b1;
                end
                OP_ADD: begin
                    w_acc_nxt   = w_sum[7:0];
                    w_carry_nxt = w_sum[8];
                    w_zero_upd  = 1'b1;
                end
                OP_SUB: begin
                    // Bit 8 of the 9-bit difference is the borrow.
                    w_acc_nxt   = w_diff[7:0];
                    w_carry_nxt = w_diff[8];
                    w_zero_upd  = 1'b1;
                end
                OP_AND: begin
                    w_acc_nxt  = r_acc & rf_rdata;
                    w_zero_upd = 1'b1;
                end
                OP_LDI: begin
                    w_acc_nxt  = r_operand;
                    w_zero_upd = 1'b1;
                end
                default: begin
                    w_acc_nxt   = r_acc;
                    w_carry_nxt = r_carry;
                    w_zero_upd  = 1'b0;
                end
            endcase
        end else begin
            w_acc_nxt   = r_acc;
            w_carry_nxt = r_carry;
            w_zero_upd  = 1'b0;
        end
        if (w_zero_upd) w_zero_nxt = (w_acc_nxt == 8'h00);
        else            w_zero_nxt = r_zero;
    end

    // Sequencer state and program counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Instruction and operand latches, loaded on the fetch handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 4'h0;
            r_reg     <= 2'd0;
            r_operand <= 8'h00;
        end else if (w_hs && (r_state == ST_FETCH)) begin
            r_op      <= instr_data[7:4];
            r_reg     <= instr_data[1:0];
            r_operand <= r_operand;
        end else if (w_hs && (r_state == ST_FETCH_OP)) begin
            r_op      <= r_op;
            r_reg     <= r_reg;
            r_operand <= instr_data;
        end else begin
            r_op      <= r_op;
            r_reg     <= r_reg;
            r_operand <= r_operand;
        end
    end

    // Accumulator and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= 8'h00;
            r_zero  <= 1'b1;
            r_carry <= 1'b0;
        end else begin
            r_acc   <= w_acc_nxt;
            r_zero  <= w_zero_nxt;
            r_carry <= w_carry_nxt;
        end
    end

    // Control outputs registered from the next-state decode so that they
    // are glitch-free and aligned with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_req <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_rf_we     <= 1'b0;
            r_rf_addr   <= 2'd0;
            r_illegal   <= 1'b0;
        end else begin
            r_instr_req <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_FETCH_OP);
            r_busy      <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_FETCH_OP) ||
                           (w_state_nxt == ST_EXEC);
            r_halted    <= (w_state_nxt == ST_HALT);
            r_rf_we     <= w_enter_exec && (w_exec_op == OP_STA);
            r_rf_addr   <= w_enter_exec ? w_exec_reg : 2'd0;
            r_illegal   <= w_enter_exec && f_illegal(w_exec_op);
        end
    end

    assign instr_req  = r_instr_req;
    assign instr_addr = r_pc;
    assign rf_addr    = r_rf_addr;
    assign rf_we      = r_rf_we;
    assign rf_wdata   = r_acc;
    assign acc        = r_acc;
    assign zero       = r_zero;
    assign carry      = r_carry;
    assign busy       = r_busy;
    assign halted     = r_halted;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_accumulator_control_unit.sv
// Scoreboard bench for accumulator_control_unit: directed programs are loaded
// into a behavioural program memory, expected register-file writes, illegal
// pulses and halt snapshots are queued, and a monitor compares them as the
// DUT produces them.

module tb_accumulator_control_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid;
    logic [7:0]  instr_data;
    logic [1:0]  rf_addr;
    logic        rf_we;
    logic [7:0]  rf_wdata;
    logic [7:0]  rf_rdata;
    logic [7:0]  acc;
    logic        zero;
    logic        carry;
    logic        busy;
    logic        halted;
    logic        illegal;

    accumulator_control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .rf_addr     (rf_addr),
        .rf_we       (rf_we),
        .rf_wdata    (rf_wdata),
        .rf_rdata    (rf_rdata),
        .acc         (acc),
        .zero        (zero),
        .carry       (carry),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Program memory with programmable wait states
    logic [7:0] mem [256];
    int         mem_wait    = 0;
    logic       valid_force = 1'b0;
    int         wait_cnt    = 0;

    assign instr_valid = valid_force | (instr_req && (wait_cnt >= mem_wait));
    assign instr_data  = mem[instr_addr];

    always @(posedge clk) begin
        if (!instr_req || instr_valid) wait_cnt <= 0;
        else                           wait_cnt <= wait_cnt + 1;
    end

    // Register file model (combinational read, clocked write)
    logic [7:0] rf [4];
    logic [7:0] rf_init [4];
    logic       rf_load = 1'b0;
    assign rf_rdata = rf[rf_addr];

    always @(posedge clk) begin
        if (rf_load) for (int i = 0; i < 4; i++) rf[i] <= rf_init[i];
        else if (rf_we) rf[rf_addr] <= rf_wdata;
    end

    // Counts accepted fetches at address 2 (loop body of the JNZ test)
    int fetch2_cnt = 0;
    always @(posedge clk) begin
        if (instr_req && instr_valid && (instr_addr == 8'd2)) fetch2_cnt <= fetch2_cnt + 1;
    end

    // Scoreboard
    typedef struct packed {
        logic [1:0] kind;   // 1 = rf write, 2 = halt, 3 = illegal
        logic [7:0] a;
        logic [7:0] d;
        logic       z;
        logic       c;
    } ev_t;

    ev_t exp_q [$];

    function automatic ev_t ev_wr(input logic [1:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = 2'd1; e.a = {6'd0, a}; e.d = d; e.z = 1'b0; e.c = 1'b0;
        return e;
    endfunction

    function automatic ev_t ev_halt(input logic [7:0] pc, input logic [7:0] d,
                                    input logic z, input logic c);
        ev_t e;
        e.kind = 2'd2; e.a = pc; e.d = d; e.z = z; e.c = c;
        return e;
    endfunction

    function automatic ev_t ev_ill(input logic [7:0] d);
        ev_t e;
        e.kind = 2'd3; e.a = 8'h00; e.d = d; e.z = 1'b0; e.c = 1'b0;
        return e;
    endfunction

    task automatic sb_check(input ev_t act);
        ev_t exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got kind=%0d a=%h d=%h z=%b c=%b, none expected",
                     act.kind, act.a, act.d, act.z, act.c);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL sb_event: got kind=%0d a=%h d=%h z=%b c=%b, expected kind=%0d a=%h d=%h z=%b c=%b",
                         act.kind, act.a, act.d, act.z, act.c,
                         exp.kind, exp.a, exp.d, exp.z, exp.c);
            end
        end
    endtask

    // Monitor: every DUT output event is compared against the queue head
    logic prev_halted = 1'b0;
    always @(negedge clk) begin
        if (rf_we)                   sb_check(ev_wr(rf_addr, rf_wdata));
        if (illegal)                 sb_check(ev_ill(acc));
        if (halted && !prev_halted)  sb_check(ev_halt(instr_addr, acc, zero, carry));
        prev_halted = halted;
    end

    // Wait-state stability checker: while a request waits, address and
    // accumulator must hold and no register write may occur.
    logic       chk_stable = 1'b0;
    int         stable_cnt = 0;
    logic [7:0] hold_addr  = 8'h00;
    logic [7:0] hold_acc   = 8'h00;
    always @(negedge clk) begin
        if (chk_stable && instr_req && (wait_cnt != 0)) begin
            n_checks++;
            stable_cnt++;
            if ((instr_addr !== hold_addr) || (acc !== hold_acc) || (rf_we !== 1'b0)) begin
                n_fail++;
                $display("FAIL wait_stable: got addr=%h acc=%h we=%b, expected addr=%h acc=%h we=0",
                         instr_addr, acc, rf_we, hold_addr, hold_acc);
            end
        end
        hold_addr = instr_addr;
        hold_acc  = acc;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic load_prog(input logic [7:0] bytes [$]);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < bytes.size(); i++) mem[i] = bytes[i];
    endtask

    // Pulses start and waits for HALT; cyc counts clock edges after the
    // edge that samples start. A one-cycle extra start pulse is injected
    // at cycle glitch_at (while the core is busy) when glitch_at >= 0.
    task automatic run_prog(input int glitch_at, output int cyc);
        cyc = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (!halted && (cyc < 2000)) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == glitch_at);
        end
        start = 1'b0;
        n_checks++;
        if (!halted) begin
            n_fail++;
            $display("FAIL halt_timeout: got halted=0 after %0d cycles, expected halted=1", cyc);
        end
        @(negedge clk); @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int f2;
        start   = 1'b0;
        rst_n   = 1'b0;
        rf_init[0] = 8'h01; rf_init[1] = 8'h00; rf_init[2] = 8'h00; rf_init[3] = 8'h01;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rf_load = 1'b1;
        @(posedge clk); #1 rf_load = 1'b0;
        @(negedge clk);
        // Reset state: IDLE, acc=0, zero=1, carry=0, all strobes low, rf_addr=0
        check("reset_acc",   acc, 8'h00);
        check("reset_flags", {zero, carry}, 2'b10);
        check("reset_ctl",   {busy, halted, instr_req, rf_we, illegal, rf_addr}, 7'b0);
        check("reset_pc",    instr_addr, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: LDI 5; STA r1; LDI 3; ADD r1; HLT with zero wait states.
        // 2-byte ops take 3 cycles, 1-byte ops 2: 3+2+3+2+2 = 12 to HALT.
        load_prog('{8'h60, 8'h05, 8'h21, 8'h60, 8'h03, 8'h31, 8'hF0});
        exp_q.push_back(ev_wr(2'd1, 8'h05));
        exp_q.push_back(ev_halt(8'd7, 8'h08, 1'b0, 1'b0));
        run_prog(-1, cyc);
        check("t1_cycles", cyc, 12);
        check("t1_rf1", rf[1], 8'h05);

        // T2: LDI FF; STA r2; LDI 1; ADD r2 -> 0x100: acc=0 zero=1 carry=1.
        // A start pulse while busy must be ignored (a restart would repeat the write).
        load_prog('{8'h60, 8'hFF, 8'h22, 8'h60, 8'h01, 8'h32, 8'hF0});
        exp_q.push_back(ev_wr(2'd2, 8'hFF));
        exp_q.push_back(ev_halt(8'd7, 8'h00, 1'b1, 1'b1));
        run_prog(3, cyc);

        // T3a: LDI 0; SUB r3 (=1) -> acc=FF, borrow=1, zero=0
        load_prog('{8'h60, 8'h00, 8'h43, 8'hF0});
        exp_q.push_back(ev_halt(8'd4, 8'hFF, 1'b0, 1'b1));
        run_prog(-1, cyc);
        // T3b: LDA r0 (=1) -> acc=01, carry untouched (still 1)
        load_prog('{8'h10, 8'hF0});
        exp_q.push_back(ev_halt(8'd2, 8'h01, 1'b0, 1'b1));
        run_prog(-1, cyc);

        // T4: LDI 3; SUB r0; JNZ 2; HLT. SUB at 2 runs 3 times (JNZ taken
        // twice), last SUB 1-1 leaves acc=0 zero=1 no borrow; HLT at 5 -> PC=6.
        // instr_valid is held high throughout to show it is ignored without a request.
        load_prog('{8'h60, 8'h03, 8'h40, 8'h70, 8'h02, 8'hF0});
        exp_q.push_back(ev_halt(8'd6, 8'h00, 1'b1, 1'b0));
        valid_force = 1'b1;
        f2 = fetch2_cnt;
        run_prog(-1, cyc);
        valid_force = 1'b0;
        check("t4_loop_fetches", fetch2_cnt - f2, 3);

        // T5: 4 wait states per byte; LDI 2A; STA r3; HLT
        load_prog('{8'h60, 8'h2A, 8'h23, 8'hF0});
        exp_q.push_back(ev_wr(2'd3, 8'h2A));
        exp_q.push_back(ev_halt(8'd4, 8'h2A, 1'b0, 1'b0));
        mem_wait   = 4;
        chk_stable = 1'b1;
        run_prog(-1, cyc);
        chk_stable = 1'b0;
        mem_wait   = 0;
        check("t5_wait_seen", (stable_cnt > 0) ? 1 : 0, 1);

        // T6: LDI 33; 0x92 (undefined) -> one illegal pulse, acc unchanged
        load_prog('{8'h60, 8'h33, 8'h92, 8'hF0});
        exp_q.push_back(ev_ill(8'h33));
        exp_q.push_back(ev_halt(8'd4, 8'h33, 1'b0, 1'b0));
        run_prog(-1, cyc);
        check("t6_rf2", rf[2], 8'hFF);

        // T7: reset during EXEC of STA r1 -> write aborted, back to IDLE, acc=0
        load_prog('{8'h60, 8'h77, 8'h21, 8'hF0});
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!(instr_req && instr_valid && (instr_data == 8'h21)) && (cyc < 200)) begin
            @(negedge clk); cyc++;
        end
        check("t7_sta_fetched", (cyc < 200) ? 1 : 0, 1);
        @(posedge clk); #1;
        check("t7_exec_we", rf_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t7_we_abort", rf_we, 1'b0);
        @(negedge clk); @(negedge clk);
        check("t7_acc", acc, 8'h00);
        check("t7_flags", {zero, carry}, 2'b10);
        check("t7_ctl", {busy, halted, instr_req, rf_we, illegal, rf_addr}, 7'b0);
        check("t7_rf1_kept", rf[1], 8'h05);
        rst_n = 1'b1;
        @(negedge clk);
        check("t7_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
